// File: rtl/ising_run_ctrl.sv
// Run sequencer for one Ising anneal: streams weights into core_matrix,
// holds the oscillators in reset, runs them, then captures the spin vector.
module ising_run_ctrl #(
  parameter int unsigned N           = 8,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned RST_HOLD    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          axi_rst,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   load_count,
  input  logic [31:0]   run_cycles,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [15:0]   w_s,
  input  logic [14:0]   w_d,
  input  logic [31:0]   w_data,
  output logic          wready,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wdata,
  output logic          ising_rstn,
  input  logic [N-1:0]  outputs_ver,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          idx_err
);

  localparam int unsigned HW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, CAPTURE} state_t;

  state_t        state, state_nx;
  logic [15:0]   load_cnt;
  logic [31:0]   run_cnt;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic          accept;
  logic          beat;
  logic          in_range;

  assign w_ready    = (state == LOAD);
  assign busy       = (state != IDLE);
  assign ising_rstn = (state == RUN);
  assign accept     = (state == IDLE) && start && !abort;
  assign beat       = w_ready && w_valid && !abort;
  assign in_range   = ({16'd0, w_s} < 32'(N)) && ({17'd0, w_d} < 32'(N));

  always_comb begin
    state_nx = state;
    if (abort && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = (load_count != '0) ? LOAD : HOLD;
        LOAD:    if (w_valid && load_cnt == 16'd1) state_nx = HOLD;
        HOLD:    if (hold_cnt == HW'(RST_HOLD - 1)) state_nx = RUN;
        RUN:     if (run_cnt == 32'd1) state_nx = CAPTURE;
        CAPTURE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (axi_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      load_cnt <= '0;
      run_cnt  <= '0;
      hold_cnt <= '0;
      wready   <= 1'b0;
      wr_addr  <= '0;
      wdata    <= '0;
      done     <= 1'b0;
      result   <= '0;
      idx_err  <= 1'b0;
    end else begin
      wready   <= 1'b0;
      done     <= 1'b0;
      hold_cnt <= '0;
      if (accept) begin
        load_cnt <= load_count;
        run_cnt  <= (run_cycles == '0) ? 32'd1 : run_cycles;
        idx_err  <= 1'b0;
      end
      // Out-of-range beats are consumed (count advances) but never strobed.
      if (beat) begin
        if (load_cnt != '0) load_cnt <= load_cnt - 16'd1;
        if (in_range) begin
          wready  <= 1'b1;
          wr_addr <= ADDR_BASE | {1'b0, w_d, w_s};
          wdata   <= w_data;
        end else begin
          idx_err <= 1'b1;
        end
      end
      if (state == HOLD && !abort && hold_cnt != HW'(RST_HOLD - 1))
        hold_cnt <= hold_cnt + HW'(1);
      if (state == RUN && !abort && run_cnt != 32'd1)
        run_cnt <= run_cnt - 32'd1;
      if (state == CAPTURE && !abort) begin
        result <= sync_q[SYNC_STAGES-1];
        done   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (axi_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= outputs_ver;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Scoreboarded bench for ising_run_ctrl: write strobes and captured results
// are queued when stimulus is driven and checked when the DUT emits them.
module tb_ising_run_ctrl;

  localparam int unsigned N        = 8;
  localparam int unsigned RST_HOLD = 4;

  logic          clk = 1'b0;
  logic          axi_rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   load_count = '0;
  logic [31:0]   run_cycles = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [15:0]   w_s = '0;
  logic [14:0]   w_d = '0;
  logic [31:0]   w_data = '0;
  logic          wready;
  logic [31:0]   wr_addr;
  logic [31:0]   wdata;
  logic          ising_rstn;
  logic [N-1:0]  outputs_ver = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;
  logic          idx_err;

  int total = 0;
  int bad   = 0;
  logic [63:0]  wq [$];
  logic [N-1:0] rq [$];

  int lo, hi;
  bit got, busy_at, err_at;

  always #5 clk = ~clk;

  ising_run_ctrl #(
    .N(N), .ADDR_BASE(32'h0000_0000), .RST_HOLD(RST_HOLD), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .axi_rst(axi_rst), .start(start), .abort(abort),
    .load_count(load_count), .run_cycles(run_cycles),
    .w_valid(w_valid), .w_ready(w_ready), .w_s(w_s), .w_d(w_d), .w_data(w_data),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata), .ising_rstn(ising_rstn),
    .outputs_ver(outputs_ver), .busy(busy), .done(done), .result(result),
    .idx_err(idx_err)
  );

  // Scoreboard monitor: pops expectations as strobes and done pulses appear.
  always @(negedge clk) begin
    logic [63:0]  ew;
    logic [N-1:0] er;
    if (wready === 1'b1) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: addr=%h data=%h, required no strobe", wr_addr, wdata);
      end else begin
        ew = wq.pop_front();
        if ({wr_addr, wdata} !== ew) begin
          bad++;
          $display("FAIL strobe_payload: addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wdata, ew[63:32], ew[31:0]);
        end
      end
    end
    if (done === 1'b1) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: result=%h, required no done", result);
      end else begin
        er = rq.pop_front();
        if (result !== er) begin
          bad++;
          $display("FAIL result: got %h, required %h", result, er);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] lc, input logic [31:0] rc);
    load_count = lc;
    run_cycles = rc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic [15:0] s, input logic [14:0] d, input logic [31:0] data,
                            input bit push, input logic [31:0] exp_addr);
    w_valid = 1'b1;
    w_s = s;
    w_d = d;
    w_data = data;
    if (push) wq.push_back({exp_addr, data});
  endtask

  task automatic wait_done(output int lo_c, output int hi_c, output bit got_d,
                           output bit busy_d, output bit err_d);
    lo_c = 0; hi_c = 0; got_d = 0; busy_d = 1'b1; err_d = 1'b0;
    for (int c = 0; c < 300 && !got_d; c++) begin
      if (done === 1'b1) begin
        got_d = 1;
        busy_d = busy;
        err_d = idx_err;
      end else begin
        if (ising_rstn === 1'b1) hi_c++;
        else if (hi_c == 0) lo_c++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    axi_rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({w_ready, wready, wr_addr, wdata, ising_rstn, busy, done, result, idx_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: w_ready=%b wready=%b addr=%h data=%h rstn=%b busy=%b done=%b result=%h err=%b, required all 0",
               w_ready, wready, wr_addr, wdata, ising_rstn, busy, done, result, idx_err);
    end
    axi_rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_run();
    rq.push_back(8'h00);
    start_run(16'd0, 32'd5);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_rise: got %b, required 1", busy);
    end
    wait_done(lo, hi, got, busy_at, err_at);
    total++;
    if (lo != RST_HOLD) begin
      bad++; $display("FAIL hold_len: got %0d, required %0d", lo, RST_HOLD);
    end
    total++;
    if (hi != 5) begin
      bad++; $display("FAIL run_len: got %0d, required 5", hi);
    end
    total++;
    if (!got || busy_at !== 1'b0) begin
      bad++; $display("FAIL done_busy: got_done=%0d busy=%b, required 1 and 0", got, busy_at);
    end
    tick();
  endtask

  task automatic test_load_b2b();
    logic [3:0] seen;
    rq.push_back(8'h00);
    start_run(16'd3, 32'd2);
    total++;
    if (w_ready !== 1'b1) begin
      bad++; $display("FAIL load_ready: got %b, required 1", w_ready);
    end
    drive_beat(16'd1, 15'd2, 32'h0000_000A, 1, 32'h0002_0001);
    tick(); seen[3] = wready;
    drive_beat(16'd7, 15'd0, 32'h0000_000B, 1, 32'h0000_0007);
    tick(); seen[2] = wready;
    drive_beat(16'd3, 15'd3, 32'h0000_000C, 1, 32'h0003_0003);
    tick(); seen[1] = wready;
    w_valid = 1'b0;
    total++;
    if (w_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_load: got %b, required 0", w_ready);
    end
    tick(); seen[0] = wready;
    total++;
    if (seen !== 4'b1110) begin
      bad++; $display("FAIL b2b_strobes: got %b, required 1110", seen);
    end
    wait_done(lo, hi, got, busy_at, err_at);
    total++;
    if (!got || err_at !== 1'b0) begin
      bad++; $display("FAIL load_done: got_done=%0d idx_err=%b, required 1 and 0", got, err_at);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    rq.push_back(8'h00);
    start_run(16'd2, 32'd1);
    drive_beat(16'd8, 15'd0, 32'h0000_00E1, 0, 32'h0);
    tick();
    drive_beat(16'd0, 15'd9, 32'h0000_00E2, 0, 32'h0);
    tick();
    w_valid = 1'b0;
    wait_done(lo, hi, got, busy_at, err_at);
    total++;
    if (!got || err_at !== 1'b1) begin
      bad++; $display("FAIL oor_err: got_done=%0d idx_err=%b, required 1 and 1", got, err_at);
    end
    tick();
    total++;
    if (idx_err !== 1'b1) begin
      bad++; $display("FAIL oor_sticky: got %b, required 1", idx_err);
    end
    rq.push_back(8'h00);
    start_run(16'd0, 32'd1);
    total++;
    if (idx_err !== 1'b0) begin
      bad++; $display("FAIL oor_clear: got %b, required 0", idx_err);
    end
    wait_done(lo, hi, got, busy_at, err_at);
    total++;
    if (!got) begin
      bad++; $display("FAIL oor_rerun: done not seen, required done");
    end
    tick();
  endtask

  task automatic test_capture();
    rq.push_back(8'h5A);
    start_run(16'd0, 32'd10);
    outputs_ver = 8'h5A;
    // A start while busy must not reload run_cycles.
    start = 1'b1;
    run_cycles = 32'd99;
    tick();
    start = 1'b0;
    wait_done(lo, hi, got, busy_at, err_at);
    total++;
    if (!got || hi != 10) begin
      bad++; $display("FAIL capture_run: got_done=%0d run_len=%0d, required 1 and 10", got, hi);
    end
    outputs_ver = 8'hFF;
    repeat (5) tick();
    total++;
    if (result !== 8'h5A) begin
      bad++; $display("FAIL result_hold: got %h, required 5a", result);
    end
  endtask

  task automatic test_abort();
    outputs_ver = 8'h33;
    start_run(16'd0, 32'd10);
    for (int c = 0; c < 40 && ising_rstn !== 1'b1; c++) tick();
    total++;
    if (ising_rstn !== 1'b1) begin
      bad++; $display("FAIL abort_reach_run: rstn=%b, required 1", ising_rstn);
    end
    tick();
    tick();
    abort = 1'b1;
    start = 1'b1;
    run_cycles = 32'd7;
    tick();
    total++;
    if ({busy, ising_rstn, done, wready} !== 4'b0000 || result !== 8'h5A) begin
      bad++;
      $display("FAIL abort_idle: busy=%b rstn=%b done=%b wready=%b result=%h, required 0 0 0 0 5a",
               busy, ising_rstn, done, wready, result);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_start_same: busy=%b, required 0", busy);
    end
    abort = 1'b0;
    rq.push_back(8'h33);
    start_run(16'd0, 32'd3);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL start_after_abort: busy=%b, required 1", busy);
    end
    wait_done(lo, hi, got, busy_at, err_at);
    total++;
    if (!got || hi != 3) begin
      bad++; $display("FAIL post_abort_run: got_done=%0d run_len=%0d, required 1 and 3", got, hi);
    end
    tick();
  endtask

  task automatic test_stall();
    int viol;
    rq.push_back(8'h33);
    start_run(16'd4, 32'd2);
    drive_beat(16'd0, 15'd0, 32'h0000_0011, 1, 32'h0000_0000);
    tick();
    drive_beat(16'd5, 15'd6, 32'h0000_0022, 1, 32'h0006_0005);
    tick();
    w_valid = 1'b0;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (w_ready !== 1'b1 || busy !== 1'b1 || wready !== 1'b0) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL stall_hold: %0d bad cycles, required 0", viol);
    end
    drive_beat(16'd7, 15'd7, 32'h0000_0033, 1, 32'h0007_0007);
    tick();
    drive_beat(16'd2, 15'd4, 32'h0000_0044, 1, 32'h0004_0002);
    tick();
    w_valid = 1'b0;
    wait_done(lo, hi, got, busy_at, err_at);
    total++;
    if (!got || err_at !== 1'b0) begin
      bad++; $display("FAIL stall_done: got_done=%0d idx_err=%b, required 1 and 0", got, err_at);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    start_run(16'd0, 32'd10);
    for (int c = 0; c < 40 && ising_rstn !== 1'b1; c++) tick();
    tick();
    axi_rst = 1'b1;
    tick();
    total++;
    if ({ising_rstn, busy, wready, done, result, idx_err} !== '0) begin
      bad++;
      $display("FAIL reset_midrun: rstn=%b busy=%b wready=%b done=%b result=%h err=%b, required all 0",
               ising_rstn, busy, wready, done, result, idx_err);
    end
    axi_rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_run();
    test_load_b2b();
    test_out_of_range();
    test_capture();
    test_abort();
    test_stall();
    test_reset_midrun();
    repeat (3) tick();
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: strobes left=%0d results left=%0d, required 0 and 0",
               wq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ising_run_ctrl.md
Name: ising_run_ctrl

Overview:
Sequencer that drives one complete Ising anneal on core_matrix. It streams coupling weights into the matrix write port (wready/wr_addr/wdata), holds the oscillators in reset, then releases them for a programmed number of cycles. At the end of the run it captures the synchronized outputs_ver spin vector. It sits between the host-side command/weight stream and core_matrix, in the clk domain.

Parameters:
N, 8, matrix dimension (width of spin vector; power of 2, 2..32768)
ADDR_BASE, 32'h0000_0000, value OR-ed into every wr_addr; must match the weight address decode
RST_HOLD, 4, cycles ising_rstn is held low after loading, before the run (>=1)
SYNC_STAGES, 2, flop stages on outputs_ver before capture (>=2)

Ports:
clk  input  1  system clock
axi_rst  input  1  synchronous active-high reset
start  input  1  one-cycle command pulse; accepted only in IDLE
abort  input  1  cancel the current run; returns to IDLE
load_count  input  16  number of weight beats to consume (sampled on start)
run_cycles  input  32  oscillation cycles (sampled on start; 0 treated as 1)
w_valid  input  1  weight beat valid
w_ready  output  1  weight beat accepted when w_valid&w_ready
w_s  input  16  source index of beat
w_d  input  15  destination index of beat
w_data  input  32  weight payload
wready  output  1  one-cycle write strobe to core_matrix
wr_addr  output  32  ADDR_BASE | {1'b0, w_d, w_s}
wdata  output  32  weight to core_matrix
ising_rstn  output  1  oscillator reset to core_matrix, active low
outputs_ver  input  N  asynchronous spin outputs from core_matrix
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when result is updated
result  output  N  captured spin vector, held until next done
idx_err  output  1  sticky: a beat with w_s>=N or w_d>=N was dropped; cleared on accepted start

Behaviour:
- Reset (axi_rst=1 at a clk edge): state=IDLE. ising_rstn=0, wready=0, wr_addr=0, wdata=0, w_ready=0, busy=0, done=0, result=0, idx_err=0. Synchronizer flops=0.
- States: IDLE, LOAD, HOLD, RUN, CAPTURE.
- IDLE: ising_rstn=0. On start, latch load_count and run_cycles (0 becomes 1) and clear idx_err. Next state is LOAD if load_count!=0, else HOLD. busy rises the cycle after start.
- LOAD: w_ready = (state==LOAD), combinational from state only. On each handshake, the remaining count decrements.
  - In-range beat: on the next cycle wready=1 for exactly one cycle, with wr_addr/wdata registered from that beat.
  - Out-of-range beat: consumed, no strobe issued, idx_err set.
  - Back-to-back beats give back-to-back strobes (1 beat/cycle).
  - After the last handshake, the next state is HOLD. The final strobe appears in the first HOLD cycle.
  - w_valid low stalls indefinitely; there is no timeout.
- HOLD: ising_rstn=0 for exactly RST_HOLD cycles, then RUN.
- RUN: ising_rstn=1 for exactly run_cycles cycles, then CAPTURE.
- CAPTURE: one cycle. result <= synchronizer output (outputs_ver after SYNC_STAGES flops, always running). done=1 in the cycle after CAPTURE, together with the return to IDLE. ising_rstn=0 again from IDLE.
- abort: highest priority after reset. In any non-IDLE state, the next cycle is IDLE with ising_rstn=0, wready=0, no done, and result unchanged. An in-flight write strobe already registered still completes that cycle. abort in IDLE is ignored. abort and start in the same IDLE cycle: start is ignored.
- start while busy: ignored, and latched values are unchanged.
- Counters: 16-bit load down-counter, 32-bit run down-counter; no wrap, since each counter stops at its terminal value.
- Reset mid-run: immediate return to reset values, including ising_rstn=0.

Test Plan:
- Reset then idle: axi_rst 3 cycles -> all outputs 0, w_ready=0, busy=0; start with no stream and load_count=0, run_cycles=5 -> ising_rstn low 4 cycles, high exactly 5 cycles, done pulse, busy drops same cycle as done.
- Load 3 beats back-to-back, N=8: (s=1,d=2,0xA), (s=7,d=0,0xB), (s=3,d=3,0xC) -> three consecutive wready pulses, wr_addr=0x0002_0001, 0x0000_0007, 0x0003_0003, wdata matching; idx_err=0.
- Out-of-range: load_count=2 with beats (s=8,d=0) and (s=0,d=9) at N=8 -> no wready pulses, idx_err=1 through done; next start clears it.
- Capture: outputs_ver forced to 8'h5A during RUN, run_cycles=10 -> result=8'h5A on the done cycle, held after outputs_ver changes.
- Abort in RUN at cycle 3 of 10 -> next cycle IDLE, ising_rstn=0, no done, result unchanged; start ignored in the abort cycle, accepted the cycle after.
- Stall: w_valid low 20 cycles mid-LOAD -> state remains LOAD, no strobes, busy=1; resume completes the load normally.
